// File: rtl/adv_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adv_cnt_pkg
// Purpose  : Shared types for the parametrised up/down counter.
// Revision : 1.0
// ============================================================================
package adv_cnt_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/adv_cnt_next.sv
`default_nettype none
// ============================================================================
// Module   : adv_cnt_next
// Purpose  : Next-count arithmetic with bound-crossing detection.
// Revision : 1.0
// ============================================================================
module adv_cnt_next #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] lo_bound,
  input  logic [WIDTH-1:0] hi_bound,
  input  logic             up,
  output logic [WIDTH-1:0] next_val,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  // One extra bit keeps the carry/borrow visible for the bound compare.
  assign w_sum  = {1'b0, count} + {1'b0, step};
  assign w_diff = {1'b0, count} - {1'b0, step};

  always_comb begin
    next_val = count;
    ovf      = 1'b0;
    unf      = 1'b0;
    if (up) begin
      ovf      = (w_sum > {1'b0, hi_bound});
      next_val = w_sum[WIDTH-1:0];
    end else begin
      unf      = w_diff[WIDTH] || (w_diff[WIDTH-1:0] < lo_bound);
      next_val = w_diff[WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/adv_updown_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : adv_updown_counter_n
// Purpose  : Bounded up/down counter with wrap/saturate/one-shot modes.
// Revision : 1.0
// ============================================================================
module adv_updown_counter_n
  import adv_cnt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_inc,
  input  logic             en_dec,
  input  logic             load,
  input  logic             hold,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] lo_bound,
  input  logic [WIDTH-1:0] hi_bound,
  input  logic [1:0]       mode,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc_pulse,
  output logic             ovf_sticky,
  output logic             unf_sticky,
  output logic             done,
  output logic             at_max,
  output logic             at_min,
  output logic             cfg_err
);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;
  logic             r_unf;
  state_e           r_state;

  mode_e            w_mode;
  logic [WIDTH-1:0] w_next;
  logic             w_ovf;
  logic             w_unf;
  logic             w_count_act;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_bound_val;

  assign w_mode  = mode_e'(mode);
  assign cfg_err = (lo_bound > hi_bound);
  assign at_max  = (r_count == hi_bound);
  assign at_min  = (r_count == lo_bound);

  adv_cnt_next #(.WIDTH(WIDTH)) u_next (
    .count    (r_count),
    .step     (step),
    .lo_bound (lo_bound),
    .hi_bound (hi_bound),
    .up       (en_inc),
    .next_val (w_next),
    .ovf      (w_ovf),
    .unf      (w_unf)
  );

  // A count update happens only when nothing of higher priority is active.
  assign w_count_act = !load && !hold && (en_inc ^ en_dec) && (step != '0) &&
                       !cfg_err && (r_state == ST_RUN);

  always_comb begin
    w_load_val = load_value;
    if (!cfg_err) begin
      if (load_value < lo_bound)      w_load_val = lo_bound;
      else if (load_value > hi_bound) w_load_val = hi_bound;
    end
  end

  always_comb begin
    case (w_mode)
      MODE_SAT, MODE_ONESHOT: w_bound_val = w_ovf ? hi_bound : lo_bound;
      default:                w_bound_val = w_ovf ? lo_bound : hi_bound;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_state <= ST_RUN;
    end else begin
      r_tc  <= 1'b0;
      r_ovf <= (w_count_act && w_ovf) || (r_ovf && !clr_flags);
      r_unf <= (w_count_act && w_unf) || (r_unf && !clr_flags);
      if (load) begin
        r_count <= w_load_val;
        r_state <= ST_RUN;
      end else if (w_count_act) begin
        if (w_ovf || w_unf) begin
          r_tc    <= 1'b1;
          r_count <= w_bound_val;
          if (w_mode == MODE_ONESHOT) r_state <= ST_DONE;
        end else begin
          r_count <= w_next;
        end
      end
    end
  end

  assign count      = r_count;
  assign tc_pulse   = r_tc;
  assign ovf_sticky = r_ovf;
  assign unf_sticky = r_unf;
  assign done       = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_adv_updown_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_adv_updown_counter_n
// Purpose  : Directed and randomized checks against an integer model.
// Revision : 1.0
// ============================================================================
module tb_adv_updown_counter_n;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, en_inc, en_dec, load, hold, clr_flags;
  logic [W-1:0] load_value, step, lo_bound, hi_bound;
  logic [1:0]   mode;
  logic [W-1:0] count;
  logic         tc_pulse, ovf_sticky, unf_sticky, done, at_max, at_min, cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_count = 0;
  bit m_tc = 0, m_ovf = 0, m_unf = 0, m_done = 0;

  adv_updown_counter_n #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en_inc(en_inc), .en_dec(en_dec), .load(load),
    .hold(hold), .load_value(load_value), .step(step), .lo_bound(lo_bound),
    .hi_bound(hi_bound), .mode(mode), .clr_flags(clr_flags), .count(count),
    .tc_pulse(tc_pulse), .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky),
    .done(done), .at_max(at_max), .at_min(at_min), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int lo, hi, s, lv, c, t;
    bit cerr, so, su;
    lo = int'(lo_bound); hi = int'(hi_bound); s = int'(step);
    lv = int'(load_value); cerr = (lo > hi);
    if (rst) begin
      m_count = 0; m_tc = 0; m_ovf = 0; m_unf = 0; m_done = 0;
      return;
    end
    c = m_count; so = 0; su = 0;
    m_tc = 0;
    if (load) begin
      if (cerr)        c = lv;
      else if (lv < lo) c = lo;
      else if (lv > hi) c = hi;
      else             c = lv;
      m_done = 0;
    end else if (!hold && (en_inc != en_dec) && s != 0 && !cerr && !m_done) begin
      t = en_inc ? c + s : c - s;
      if (en_inc && t > hi)       so = 1;
      else if (!en_inc && t < lo) su = 1;
      if (so || su) begin
        m_tc = 1;
        if (mode == 2'd1 || mode == 2'd2) c = so ? hi : lo;
        else                              c = so ? lo : hi;
        if (mode == 2'd2) m_done = 1;
      end else begin
        c = t;
      end
    end
    m_count = c;
    m_ovf = so ? 1'b1 : (clr_flags ? 1'b0 : m_ovf);
    m_unf = su ? 1'b1 : (clr_flags ? 1'b0 : m_unf);
  endtask

  // Advance one clock, keeping the model in step; outputs sampled 1ns after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; en_inc = 0; en_dec = 0; load = 0; hold = 0; clr_flags = 0;
  endtask

  task automatic do_load(input int v);
    idle_inputs(); load = 1; load_value = W'(v);
    cycle();
    load = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); load_value = 0; step = 1; lo_bound = 0; hi_bound = 8'hFF; mode = 0;
    rst = 1; cycle(); cycle(); rst = 0;
    n_checks++; if (count !== 8'd0) begin n_errors++; $display("FAIL reset_count got %0d exp 0", count); end
    n_checks++; if ({tc_pulse, ovf_sticky, unf_sticky, done} !== 4'b0) begin n_errors++;
      $display("FAIL reset_flags got %b exp 0000", {tc_pulse, ovf_sticky, unf_sticky, done}); end
  endtask

  task automatic test_wrap();
    mode = 0; lo_bound = 2; hi_bound = 10; step = 3;
    do_load(9);
    n_checks++; if (count !== 8'd9) begin n_errors++; $display("FAIL wrap_load got %0d exp 9", count); end
    en_inc = 1; cycle(); en_inc = 0;
    n_checks++; if (count !== 8'd2 || tc_pulse !== 1'b1 || ovf_sticky !== 1'b1) begin n_errors++;
      $display("FAIL wrap_ovf got cnt=%0d tc=%b ovf=%b exp 2 1 1", count, tc_pulse, ovf_sticky); end
    cycle();
    n_checks++; if (tc_pulse !== 1'b0 || count !== 8'd2) begin n_errors++;
      $display("FAIL wrap_tc_one got tc=%b cnt=%0d exp 0 2", tc_pulse, count); end
  endtask

  task automatic test_saturate();
    mode = 1; lo_bound = 5; hi_bound = 30; step = 2;
    do_load(6);
    en_dec = 1; cycle();
    n_checks++; if (count !== 8'd5 || tc_pulse !== 1'b1) begin n_errors++;
      $display("FAIL sat_dec1 got cnt=%0d tc=%b exp 5 1", count, tc_pulse); end
    cycle(); en_dec = 0;
    n_checks++; if (count !== 8'd5 || tc_pulse !== 1'b1 || unf_sticky !== 1'b1) begin n_errors++;
      $display("FAIL sat_dec2 got cnt=%0d tc=%b unf=%b exp 5 1 1", count, tc_pulse, unf_sticky); end
  endtask

  task automatic test_oneshot();
    int exp_c[4] = '{19, 20, 20, 20};
    int exp_tc[4] = '{0, 0, 1, 0};
    int exp_d[4] = '{0, 0, 1, 1};
    mode = 2; lo_bound = 0; hi_bound = 20; step = 1;
    do_load(18);
    en_inc = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if (int'(count) != exp_c[i] || int'(tc_pulse) != exp_tc[i] || int'(done) != exp_d[i]) begin
        n_errors++;
        $display("FAIL oneshot_%0d got cnt=%0d tc=%b done=%b exp %0d %0d %0d",
                 i, count, tc_pulse, done, exp_c[i], exp_tc[i], exp_d[i]);
      end
    end
    en_inc = 0;
    do_load(4);
    n_checks++; if (count !== 8'd4 || done !== 1'b0) begin n_errors++;
      $display("FAIL oneshot_reload got cnt=%0d done=%b exp 4 0", count, done); end
  endtask

  task automatic test_priority();
    mode = 0; lo_bound = 0; hi_bound = 50; step = 1;
    idle_inputs(); load = 1; hold = 1; en_inc = 1; load_value = 7; cycle();
    n_checks++; if (count !== 8'd7) begin n_errors++; $display("FAIL prio_load got %0d exp 7", count); end
    idle_inputs(); en_inc = 1; en_dec = 1; cycle();
    n_checks++; if (count !== 8'd7) begin n_errors++; $display("FAIL prio_both got %0d exp 7", count); end
    idle_inputs(); hold = 1; en_inc = 1; cycle();
    n_checks++; if (count !== 8'd7) begin n_errors++; $display("FAIL prio_hold got %0d exp 7", count); end
    idle_inputs();
    do_load(200);
    n_checks++; if (count !== 8'd50 || at_max !== 1'b1) begin n_errors++;
      $display("FAIL prio_clamp got cnt=%0d at_max=%b exp 50 1", count, at_max); end
  endtask

  task automatic test_sticky_reset();
    mode = 0; lo_bound = 0; hi_bound = 50; step = 1;
    idle_inputs(); clr_flags = 1; cycle(); clr_flags = 0;
    do_load(50);
    en_inc = 1; clr_flags = 1; cycle(); idle_inputs();
    n_checks++; if (ovf_sticky !== 1'b1 || count !== 8'd0) begin n_errors++;
      $display("FAIL sticky_set_wins got ovf=%b cnt=%0d exp 1 0", ovf_sticky, count); end
    clr_flags = 1; cycle(); clr_flags = 0;
    n_checks++; if (ovf_sticky !== 1'b0) begin n_errors++; $display("FAIL sticky_clr got %b exp 0", ovf_sticky); end
    mode = 2; do_load(50);
    en_inc = 1; cycle(); en_inc = 0;
    n_checks++; if (done !== 1'b1 || ovf_sticky !== 1'b1) begin n_errors++;
      $display("FAIL done_set got done=%b ovf=%b exp 1 1", done, ovf_sticky); end
    rst = 1; cycle(); rst = 0;
    n_checks++; if ({count, tc_pulse, ovf_sticky, unf_sticky, done} !== 12'h0) begin n_errors++;
      $display("FAIL rst_from_done got cnt=%0d flags=%b exp 0 0000", count,
               {tc_pulse, ovf_sticky, unf_sticky, done}); end
  endtask

  task automatic test_cfg_err();
    mode = 0; step = 1; lo_bound = 10; hi_bound = 5; idle_inputs();
    #1;
    n_checks++; if (cfg_err !== 1'b1) begin n_errors++; $display("FAIL cfg_err got %b exp 1", cfg_err); end
    en_inc = 1; cycle(); en_inc = 0;
    n_checks++; if (count !== 8'd0 || tc_pulse !== 1'b0) begin n_errors++;
      $display("FAIL cfg_inc_ignored got cnt=%0d tc=%b exp 0 0", count, tc_pulse); end
    do_load(3);
    n_checks++; if (count !== 8'd3) begin n_errors++; $display("FAIL cfg_load_unclamped got %0d exp 3", count); end
  endtask

  task automatic test_random();
    int lo, hi;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        lo = $urandom_range(0, 120);
        hi = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(lo, 255);
        lo_bound = W'(lo); hi_bound = W'(hi);
        mode = 2'($urandom_range(0, 3));
        step = W'(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40));
      end
      rst        = ($urandom_range(0, 99) == 0);
      load       = ($urandom_range(0, 9) == 0);
      hold       = ($urandom_range(0, 9) == 0);
      en_inc     = $urandom_range(0, 1) == 1;
      en_dec     = $urandom_range(0, 1) == 1;
      clr_flags  = ($urandom_range(0, 7) == 0);
      load_value = W'($urandom_range(0, 255));
      cycle();
      n_checks++;
      if (int'(count) != m_count || tc_pulse !== m_tc || ovf_sticky !== m_ovf ||
          unf_sticky !== m_unf || done !== m_done ||
          at_max !== (m_count == int'(hi_bound)) || at_min !== (m_count == int'(lo_bound)) ||
          cfg_err !== (lo_bound > hi_bound)) begin
        n_errors++;
        $display("FAIL random_%0d got cnt=%0d tc=%b ovf=%b unf=%b done=%b exp cnt=%0d tc=%b ovf=%b unf=%b done=%b",
                 i, count, tc_pulse, ovf_sticky, unf_sticky, done, m_count, m_tc, m_ovf, m_unf, m_done);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_wrap();
    test_saturate();
    test_oneshot();
    test_priority();
    test_sticky_reset();
    test_cfg_err();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
